// File: rtl/cla_tester.sv
// Traffic source and in-order scoreboard for a pipelined carry-lookahead adder.
// Issues LFSR-derived operand pairs, queues each exact sum and checks the result stream against it.
module cla_tester #(
  parameter int             W     = 128,
  parameter int             DEPTH = 8,
  parameter logic [W-1:0]   TAPS  = 128'h8000_0000_0000_0000_0000_0000_1400_0002,
  parameter logic [W-1:0]   SEED  = W'(1)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     en,
  input  logic [1:0]               mode,
  output logic                     op_valid,
  input  logic                     op_ready,
  output logic [W-1:0]             op_a,
  output logic [W-1:0]             op_b,
  output logic                     op_cin,
  input  logic                     res_valid,
  input  logic [W-1:0]             res_sum,
  input  logic                     res_cout,
  output logic                     error,
  output logic [15:0]              err_count,
  output logic [31:0]              issued,
  output logic [31:0]              checked,
  output logic [$clog2(DEPTH):0]   outstanding
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [W-1:0]  SEED_EFF = (SEED == '0) ? W'(1) : SEED;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

  logic [W-1:0]  lfsr;
  logic [W-1:0]  lfsr_adv;
  logic [W-1:0]  lfsr_nxt;
  logic [W:0]    fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          hs;
  logic          pop;
  logic          unexpected;
  logic          mismatch;
  logic          load;
  logic          valid_nxt;
  logic [W-1:0]  b_load;
  logic          cin_load;
  logic [W:0]    op_sum;

  assign hs         = op_valid & op_ready;
  assign pop        = res_valid & (count != '0);
  assign unexpected = res_valid & (count == '0);
  assign mismatch   = pop & ({res_cout, res_sum} != fifo_mem[rd_ptr]);

  assign lfsr_adv  = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
  assign lfsr_nxt  = hs ? lfsr_adv : lfsr;
  assign op_sum    = {1'b0, op_a} + {1'b0, op_b} + {{W{1'b0}}, op_cin};

  // Capacity is judged on the occupancy after this edge's push and pop, so a
  // pop can free the slot needed by the very next operation.
  assign count_nxt = count + CW'(hs) - CW'(pop);
  assign load      = ~op_valid | hs;
  assign valid_nxt = en & (count_nxt < DEPTH_C);

  assign outstanding = count;

  // NOTE: every variable assigned in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    b_load   = ~lfsr_nxt;
    cin_load = 1'b0;
    case (mode)
      2'd0: begin
        b_load   = ~lfsr_nxt;
        cin_load = 1'b0;
      end
      2'd1: begin
        b_load   = ~lfsr_nxt;
        cin_load = 1'b1;
      end
      2'd2: begin
        b_load   = {lfsr_nxt[W-2:0], lfsr_nxt[W-1]};
        cin_load = lfsr_nxt[0];
      end
      default: begin
        b_load   = {W{1'b1}};
        cin_load = 1'b1;
      end
    endcase
  end

  // NOTE: the FIFO storage has no reset; flushing the pointers and count is enough, and keeping reset off the array lets it map to plain RAM.
  always_ff @(posedge clk) begin
    if (hs) fifo_mem[wr_ptr] <= op_sum;
  end

  // NOTE: state updates use non-blocking assignments so every register samples values from before the edge.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      lfsr      <= SEED_EFF;
      op_valid  <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      op_cin    <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      error     <= 1'b0;
      err_count <= '0;
      issued    <= '0;
      checked   <= '0;
    end else begin
      lfsr  <= lfsr_nxt;
      count <= count_nxt;

      if (hs) begin
        wr_ptr <= wr_ptr + AW'(1);
        issued <= issued + 32'd1;
      end

      if (pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        checked <= checked + 32'd1;
      end

      if (mismatch | unexpected) begin
        error <= 1'b1;
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      end

      // A stalled operation keeps its operands; only an idle or accepted slot reloads.
      if (load) begin
        op_valid <= valid_nxt;
        if (valid_nxt) begin
          op_a   <= lfsr_nxt;
          op_b   <= b_load;
          op_cin <= cin_load;
        end
      end
    end
  end

endmodule

// File: tb/tb_cla_tester.sv
// Bench for cla_tester: an ideal 3-cycle adder drives the result stream while a
// queue-based model of the tester predicts every output each cycle.
module tb_cla_tester;

  localparam int           W     = 128;
  localparam int           DEPTH = 8;
  localparam logic [W-1:0] TAPS  = 128'h8000_0000_0000_0000_0000_0000_1400_0002;
  localparam logic [W-1:0] SEED  = 128'd1;

  typedef logic [W:0] wide_t;
  typedef struct {
    int    due;
    wide_t val;
  } pend_t;

  logic          clk;
  logic          rstn;
  logic          en;
  logic [1:0]    mode;
  logic          op_valid;
  logic          op_ready;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          op_cin;
  logic          res_valid;
  logic [W-1:0]  res_sum;
  logic          res_cout;
  logic          error;
  logic [15:0]   err_count;
  logic [31:0]   issued;
  logic [31:0]   checked;
  logic [3:0]    outstanding;

  cla_tester #(.W(W), .DEPTH(DEPTH), .TAPS(TAPS), .SEED(SEED)) dut (
    .clk(clk), .rstn(rstn), .en(en), .mode(mode),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
    .res_valid(res_valid), .res_sum(res_sum), .res_cout(res_cout),
    .error(error), .err_count(err_count), .issued(issued),
    .checked(checked), .outstanding(outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Ideal adder environment
  pend_t pipe[$];
  int    n_res       = 0;
  int    flip_at     = 0;
  logic  adder_hold  = 1'b0;
  logic  release_one = 1'b0;
  logic  inj_valid   = 1'b0;
  wide_t inj_val     = '0;
  logic [W-1:0] last_hs_a;
  logic [W-1:0] last_hs_b;
  logic         last_hs_c;

  // Tester model
  logic         m_valid;
  logic [W-1:0] m_a;
  logic [W-1:0] m_b;
  logic         m_cin;
  logic [W-1:0] m_lfsr;
  wide_t        m_q[$];
  logic         m_error;
  logic [15:0]  m_errc;
  logic [31:0]  m_issued;
  logic [31:0]  m_checked;

  task automatic check(input string name, input wide_t act, input wide_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] s);
    logic [W-1:0] t;
    t = s >> 1;
    if (s[0]) t = t ^ TAPS;
    return t;
  endfunction

  function automatic wide_t add_ref(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  task automatic make_ops(input logic [W-1:0] s, input logic [1:0] md,
                          output logic [W-1:0] a, output logic [W-1:0] b, output logic c);
    a = s;
    case (md)
      2'd0:    begin b = ~s;                         c = 1'b0; end
      2'd1:    begin b = ~s;                         c = 1'b1; end
      2'd2:    begin b = (s << 1) | (s >> (W - 1)); c = s[0]; end
      default: begin b = '1;                         c = 1'b1; end
    endcase
  endtask

  task automatic model_edge(input logic r, input logic e, input logic [1:0] md,
                            input logic rdy, input logic rv, input wide_t rval);
    logic  hs;
    wide_t head;
    if (!r) begin
      m_valid = 1'b0; m_a = '0; m_b = '0; m_cin = 1'b0; m_lfsr = SEED;
      m_q.delete(); m_error = 1'b0; m_errc = '0; m_issued = '0; m_checked = '0;
      return;
    end
    hs = m_valid && rdy;
    if (rv) begin
      if (m_q.size() > 0) begin
        head = m_q.pop_front();
        m_checked++;
        if (head !== rval) begin
          m_error = 1'b1;
          if (m_errc != 16'hFFFF) m_errc++;
        end
      end else begin
        m_error = 1'b1;
        if (m_errc != 16'hFFFF) m_errc++;
      end
    end
    if (hs) begin
      m_q.push_back(add_ref(m_a, m_b, m_cin));
      m_issued++;
      m_lfsr = lfsr_step(m_lfsr);
    end
    if (!m_valid || hs) begin
      m_valid = e && (m_q.size() < DEPTH);
      if (m_valid) make_ops(m_lfsr, md, m_a, m_b, m_cin);
    end
  endtask

  task automatic compare_all();
    check("op_valid",    wide_t'(op_valid),    wide_t'(m_valid));
    check("outstanding", wide_t'(outstanding), wide_t'(m_q.size()));
    check("issued",      wide_t'(issued),      wide_t'(m_issued));
    check("checked",     wide_t'(checked),     wide_t'(m_checked));
    check("error",       wide_t'(error),       wide_t'(m_error));
    check("err_count",   wide_t'(err_count),   wide_t'(m_errc));
    if (m_valid) begin
      check("op_a",   wide_t'(op_a),   wide_t'(m_a));
      check("op_b",   wide_t'(op_b),   wide_t'(m_b));
      check("op_cin", wide_t'(op_cin), wide_t'(m_cin));
    end
  endtask

  // One clock: present adder output, take the edge, advance model, compare on the falling edge.
  task automatic tick();
    logic  hs_now;
    wide_t aval;
    pend_t p;
    res_valid = 1'b0;
    res_sum   = '0;
    res_cout  = 1'b0;
    if (inj_valid) begin
      res_valid = 1'b1;
      {res_cout, res_sum} = inj_val;
    end else if (pipe.size() > 0 && pipe[0].due <= cyc + 1 && (!adder_hold || release_one)) begin
      p = pipe.pop_front();
      n_res++;
      if (n_res == flip_at) p.val[64] = ~p.val[64];
      {res_cout, res_sum} = p.val;
      res_valid   = 1'b1;
      release_one = 1'b0;
    end
    hs_now = op_valid && op_ready && rstn;
    aval   = add_ref(op_a, op_b, op_cin);
    if (hs_now) begin
      last_hs_a = op_a;
      last_hs_b = op_b;
      last_hs_c = op_cin;
    end
    @(posedge clk);
    cyc++;
    if (!rstn) begin
      pipe.delete();
      n_res = 0;
    end else if (hs_now) begin
      p.due = cyc + 3;
      p.val = aval;
      pipe.push_back(p);
    end
    model_edge(rstn, en, mode, op_ready, res_valid, {res_cout, res_sum});
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset(input int n);
    rstn = 1'b0;
    for (int i = 0; i < n; i++) tick();
    rstn = 1'b1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_op_valid"}, wide_t'(op_valid), '0);
    check({tag, "_op_a"},     wide_t'(op_a),     '0);
    check({tag, "_op_b"},     wide_t'(op_b),     '0);
    check({tag, "_op_cin"},   wide_t'(op_cin),   '0);
    check({tag, "_error"},    wide_t'(error),    '0);
    check({tag, "_errc"},     wide_t'(err_count), '0);
    check({tag, "_issued"},   wide_t'(issued),   '0);
    check({tag, "_checked"},  wide_t'(checked),  '0);
    check({tag, "_outst"},    wide_t'(outstanding), '0);
  endtask

  logic [W-1:0] sa, sb;
  logic         sc;
  logic [31:0]  si;
  logic         flip_seen;

  initial begin
    rstn = 1'b0; en = 1'b0; mode = 2'd0; op_ready = 1'b0;
    res_valid = 1'b0; res_sum = '0; res_cout = 1'b0;

    // Reset state
    do_reset(2);
    check_reset_values("rst");

    // Mode 0 streaming with an always-ready adder
    en = 1'b1; mode = 2'd0; op_ready = 1'b1;
    tick();
    check("m0_first_a",   wide_t'(op_a),   wide_t'(128'd1));
    check("m0_first_b",   wide_t'(op_b),   {1'b0, {(W-1){1'b1}}, 1'b0});
    check("m0_first_cin", wide_t'(op_cin), '0);
    check("m0_model_sum", add_ref(m_a, m_b, m_cin), {1'b0, {W{1'b1}}});
    for (int i = 0; i < 1000; i++) begin
      tick();
      check("inv_checked", wide_t'(checked), wide_t'(issued - 32'(outstanding)));
    end
    check("m0_error_end", wide_t'(error), '0);
    check("m0_issued_min", wide_t'(issued > 32'd990), wide_t'(1));

    // Mode 1 first operation
    en = 1'b0; op_ready = 1'b0;
    do_reset(1);
    en = 1'b1; mode = 2'd1;
    tick();
    check("m1_first_a",   wide_t'(op_a),   wide_t'(128'd1));
    check("m1_first_cin", wide_t'(op_cin), wide_t'(1));
    check("m1_model_sum", add_ref(m_a, m_b, m_cin), {1'b1, {W{1'b0}}});
    op_ready = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check("m1_error", wide_t'(error), '0);

    // Mode 3 first operation
    en = 1'b0; op_ready = 1'b0;
    do_reset(1);
    en = 1'b1; mode = 2'd3;
    tick();
    check("m3_first_b",   wide_t'(op_b),   {1'b0, {W{1'b1}}});
    check("m3_model_sum", add_ref(m_a, m_b, m_cin), {1'b1, 128'd1});
    op_ready = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check("m3_error", wide_t'(error), '0);

    // Corrupted 10th result
    en = 1'b0; op_ready = 1'b0;
    do_reset(1);
    en = 1'b1; mode = 2'd0; op_ready = 1'b1; flip_at = 10; flip_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (n_res == 10 && !flip_seen) begin
        flip_seen = 1'b1;
        check("flip_error",   wide_t'(error),     wide_t'(1));
        check("flip_errc",    wide_t'(err_count), wide_t'(1));
        check("flip_checked", wide_t'(checked),   wide_t'(10));
      end
    end
    check("flip_seen", wide_t'(flip_seen), wide_t'(1));
    for (int i = 0; i < 30; i++) tick();
    check("flip_errc_after", wide_t'(err_count), wide_t'(1));
    flip_at = 0;

    // Backpressure with mode/en toggling
    en = 1'b0; op_ready = 1'b0;
    do_reset(1);
    en = 1'b1; mode = 2'd2; op_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    sa = m_a; sb = m_b; sc = m_cin; si = m_issued;
    op_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      en   = ~en;
      mode = mode + 2'd1;
      tick();
      check("stall_valid", wide_t'(op_valid), wide_t'(1));
      check("stall_a",     wide_t'(op_a),     wide_t'(sa));
      check("stall_b",     wide_t'(op_b),     wide_t'(sb));
      check("stall_cin",   wide_t'(op_cin),   wide_t'(sc));
    end
    en = 1'b1; op_ready = 1'b1;
    tick();
    check("stall_hs_a",   wide_t'(last_hs_a), wide_t'(sa));
    check("stall_hs_b",   wide_t'(last_hs_b), wide_t'(sb));
    check("stall_hs_cin", wide_t'(last_hs_c), wide_t'(sc));
    check("stall_issued", wide_t'(issued),    wide_t'(si + 32'd1));
    for (int i = 0; i < 10; i++) tick();

    // Adder that never answers: FIFO fills to DEPTH
    en = 1'b0; op_ready = 1'b0;
    do_reset(1);
    adder_hold = 1'b1; en = 1'b1; mode = 2'd0; op_ready = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    check("full_issued",   wide_t'(issued),      wide_t'(8));
    check("full_valid",    wide_t'(op_valid),    '0);
    check("full_outst",    wide_t'(outstanding), wide_t'(8));
    release_one = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("rel_issued",  wide_t'(issued),      wide_t'(9));
    check("rel_outst",   wide_t'(outstanding), wide_t'(8));
    check("rel_checked", wide_t'(checked),     wide_t'(1));
    adder_hold = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("rel_error", wide_t'(error), '0);

    // Mixed patterns across all modes with intermittent ready and enable
    for (int i = 0; i < 300; i++) begin
      mode     = 2'((i / 7) % 4);
      op_ready = (i % 5) != 0;
      en       = (i % 37) < 30;
      tick();
    end
    check("mix_error", wide_t'(error), '0);

    // Unexpected result, then reset while an operation is pending
    en = 1'b0; op_ready = 1'b0;
    do_reset(1);
    tick();
    inj_valid = 1'b1; inj_val = {1'b1, 128'h1234};
    tick();
    inj_valid = 1'b0;
    check("unexp_error",   wide_t'(error),     wide_t'(1));
    check("unexp_errc",    wide_t'(err_count), wide_t'(1));
    check("unexp_checked", wide_t'(checked),   '0);
    en = 1'b1;
    tick();
    tick();
    check("pend_valid", wide_t'(op_valid), wide_t'(1));
    rstn = 1'b0;
    tick();
    check_reset_values("midrst");
    rstn = 1'b1; en = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cla_tester.md
# cla_tester

Self-checking traffic source and scoreboard for the pipelined carry-lookahead adder. It drives operand pairs into the adder over a valid/ready handshake and records the exact expected (W+1)-bit result of every accepted operation in an internal FIFO. It then consumes the adder's result stream, compares each result in order against the FIFO head, and reports a sticky error plus counters. It sits between the LFSR-driven test logic and the adder under test, and covers the issue side and the end-to-end comparison that a steady-state checker cannot.

## Interface
- W, 128, operand/sum width
- DEPTH, 8, expected-result FIFO depth (power of 2, ≥2); bounds outstanding operations
- TAPS, 128'h8000_0000_0000_0000_0000_0000_1400_0002, Galois right-shift mask (x^128+x^29+x^27+x^2+1)
- SEED, 1, LFSR reset value; SEED=0 is replaced by 1
- clk  in  1  clock, all logic on rising edge
- rstn  in  1  reset, synchronous, active-low
- en  in  1  allow issuing new operations
- mode  in  2  operand pattern, sampled when an operation is loaded
- op_valid  out  1  operands valid
- op_ready  in  1  adder accepts operands
- op_a, op_b  out  W  operands
- op_cin  out  1  carry in
- res_valid  in  1  result strobe, no backpressure
- res_sum  in  W  result sum
- res_cout  in  1  result carry out
- error  out  1  sticky mismatch flag
- err_count  out  16  saturating error count
- issued  out  32  accepted operations (wraps)
- checked  out  32  results compared (wraps)
- outstanding  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- LFSR s (W bits): on every handshake, s <= s[0] ? (s>>1)^TAPS : s>>1.
- Load forms op_a=s and, per mode: 0: op_b=~s, cin=0; 1: op_b=~s, cin=1; 2: op_b={s[W-2:0],s[W-1]}, cin=s[0]; 3: op_b={W{1'b1}}, cin=1.
- Handshake = op_valid & op_ready. On handshake: push {cout,sum}=op_a+op_b+op_cin (W+1 bits, computed from the registered operands) to the FIFO; issued++; LFSR advances.
- Load/raise rule: when op_valid=0 or a handshake occurs, next op_valid = en & (occupancy after this cycle's push/pop < DEPTH); if set, operands load from the (advanced) LFSR and current mode.
- While op_valid=1 and op_ready=0: op_valid, op_a, op_b, op_cin hold. Dropping en or changing mode does not withdraw or alter a pending operation.
- On res_valid with the FIFO non-empty: pop the head and checked++. If {res_cout,res_sum} ≠ head, set error and increment err_count (saturates at 16'hFFFF).
- On res_valid with the FIFO empty: unexpected result. Set error and increment err_count; no pop; checked unchanged.
- A push and a pop in the same cycle are both performed; occupancy is unchanged.
- FIFO never overflows. A handshake while occupancy=DEPTH cannot occur by construction.
- error clears only on reset.

## Timing
- Reset (rstn=0 at an edge): op_valid=0, op_a=0, op_b=0, op_cin=0, error=0, err_count=0, issued=0, checked=0, outstanding=0, FIFO flushed, s=SEED.
- Reset mid-operation aborts everything, including a pending op_valid. Results arriving after reset count as unexpected; the adder must be reset together with this block.
- First issue: the first edge with rstn=1 and en=1 raises op_valid after that edge, with op_a=SEED.
- With op_ready held at 1 and the FIFO draining, throughput is one operation per cycle.
- Compare latency: error, err_count and checked update on the edge that samples res_valid.
- outstanding reflects pushes and pops at the same edge they occur.
- No combinational path from any input to any output.

## Test plan
- SEED=1, mode 0, ideal adder model with 3-cycle latency, op_ready=1, 1000 cycles -> first op a=1, b=~1, cin=0, expected sum={W{1}}, cout=0; error=0; checked = issued − outstanding throughout.
- mode 1 and mode 3, first op -> mode 1: expected sum=0, cout=1. Mode 3 with a=1: sum=1, cout=1. Model matches, error=0.
- Model flips res_sum[64] on the 10th result -> error=1 on that edge, err_count=1, checked=10; subsequent clean results leave err_count=1.
- op_ready=0 for 5 cycles while op_valid=1, with mode and en toggled -> op_a/op_b/op_cin stable all 5 cycles; the handshake occurs on the 6th cycle with the original values.
- Adder never returns results, DEPTH=8 -> exactly 8 handshakes, then op_valid=0, outstanding=8. One result returned -> exactly one further issue.
- res_valid pulsed right after reset with the FIFO empty -> error=1, err_count=1, checked=0. Then reset mid-stream with op_valid=1 -> all outputs return to the reset values on the next edge.
